cond_unit: RTL and testbench

- Consumer end of the instruction-decoder control interface in the multicycle ARM core.
- Takes the decoder's raw write intents (FlagW, PCS, NextPC, RegW, MemW) and the instruction's condition field. Holds the architectural NZCV flags.
- Evaluates the condition once per instruction, in the Decode state, and registers the result.
- Gates every architectural write (PC, register file, memory, flags) with that registered result for the remaining states of the instruction.

---
 rtl/cond_pkg.sv | 29 ++
 rtl/cond_check.sv | 42 ++++
 rtl/cond_unit.sv | 111 +++++++++++
 tb/tb_cond_unit.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/cond_pkg.sv
// Shared condition-code definitions for the ARM condition unit and its checker.
// Holds the 4-bit condition encodings and the bit positions inside the NZCV flags word.
package cond_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_check.sv
// Purely combinational ARM condition evaluator: condition field and NZCV flags in, pass out.
// Kept free of state so a pipelined core can reuse it unchanged.
module cond_check
  import cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;

  always_comb begin
    n = flags[FLAG_N];
    z = flags[FLAG_Z];
    c = flags[FLAG_C];
    v = flags[FLAG_V];
  end

  always_comb begin
    pass = 1'b1;
    case (cond_t'(cond))
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c & !z;
      COND_LS: pass = !c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z & (n == v);
      COND_LE: pass = z | (n != v);
      // AL and the 1111 encoding both execute unconditionally
      default: pass = 1'b1;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// Condition unit: holds NZCV, latches the condition result on CondEval and gates all writes with it.
// Define CONDUNIT_PERF_EN to add the ExecCnt/SquashCnt executed/squashed instruction counters.
module cond_unit
  import cond_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       Cond,
  input  logic [3:0]       ALUFlags,
  input  logic             CondEval,
  input  logic [1:0]       FlagW,
  input  logic             PCS,
  input  logic             NextPC,
  input  logic             RegW,
  input  logic             MemW,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic [3:0]       Flags,
  output logic             CondEx
`ifdef CONDUNIT_PERF_EN
  ,
  output logic [CNT_W-1:0] ExecCnt,
  output logic [CNT_W-1:0] SquashCnt
`endif
);

  logic [3:0] flags_q, flags_d;
  logic       cond_ex_q, cond_ex_d;
  logic       cond_pass;

  // Checked against the architectural flags, never the in-flight ALU flags
  cond_check u_cond_check (
    .cond  (Cond),
    .flags (flags_q),
    .pass  (cond_pass)
  );

  always_comb begin
    cond_ex_d = cond_ex_q;
    if (CondEval) begin
      cond_ex_d = cond_pass;
    end
  end

  // Flag halves are written independently, gated by the result already held
  always_comb begin
    flags_d = flags_q;
    if (FlagW[1] && cond_ex_q) begin
      flags_d[FLAG_N] = ALUFlags[FLAG_N];
      flags_d[FLAG_Z] = ALUFlags[FLAG_Z];
    end
    if (FlagW[0] && cond_ex_q) begin
      flags_d[FLAG_C] = ALUFlags[FLAG_C];
      flags_d[FLAG_V] = ALUFlags[FLAG_V];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q   <= 4'b0000;
      cond_ex_q <= 1'b0;
    end else begin
      flags_q   <= flags_d;
      cond_ex_q <= cond_ex_d;
    end
  end

  always_comb begin
    PCWrite  = NextPC | (PCS & cond_ex_q);
    RegWrite = RegW & cond_ex_q;
    MemWrite = MemW & cond_ex_q;
    Flags    = flags_q;
    CondEx   = cond_ex_q;
  end

`ifdef CONDUNIT_PERF_EN
  logic [CNT_W-1:0] exec_cnt_q, exec_cnt_d;
  logic [CNT_W-1:0] squash_cnt_q, squash_cnt_d;

  always_comb begin
    exec_cnt_d   = exec_cnt_q;
    squash_cnt_d = squash_cnt_q;
    if (CondEval) begin
      if (cond_pass) begin
        exec_cnt_d = exec_cnt_q + 1'b1;
      end else begin
        squash_cnt_d = squash_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exec_cnt_q   <= '0;
      squash_cnt_q <= '0;
    end else begin
      exec_cnt_q   <= exec_cnt_d;
      squash_cnt_q <= squash_cnt_d;
    end
  end

  always_comb begin
    ExecCnt   = exec_cnt_q;
    SquashCnt = squash_cnt_q;
  end
`endif

endmodule

// File: tb/tb_cond_unit.sv
// Directed bench for cond_unit: reset state, gating, flag updates, condition table and
// same-cycle eval/flag-write ordering; counters are exercised when CONDUNIT_PERF_EN is defined.
module tb_cond_unit;

  localparam int CNT_W = 32;

  logic             clk;
  logic             reset;
  logic [3:0]       Cond;
  logic [3:0]       ALUFlags;
  logic             CondEval;
  logic [1:0]       FlagW;
  logic             PCS;
  logic             NextPC;
  logic             RegW;
  logic             MemW;
  logic             PCWrite;
  logic             RegWrite;
  logic             MemWrite;
  logic [3:0]       Flags;
  logic             CondEx;
`ifdef CONDUNIT_PERF_EN
  logic [CNT_W-1:0] ExecCnt;
  logic [CNT_W-1:0] SquashCnt;
`endif

  int total = 0;
  int bad   = 0;

  cond_unit #(.CNT_W(CNT_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .Cond     (Cond),
    .ALUFlags (ALUFlags),
    .CondEval (CondEval),
    .FlagW    (FlagW),
    .PCS      (PCS),
    .NextPC   (NextPC),
    .RegW     (RegW),
    .MemW     (MemW),
    .PCWrite  (PCWrite),
    .RegWrite (RegWrite),
    .MemWrite (MemWrite),
    .Flags    (Flags),
    .CondEx   (CondEx)
`ifdef CONDUNIT_PERF_EN
    ,
    .ExecCnt  (ExecCnt),
    .SquashCnt(SquashCnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    Cond = 4'b1110; ALUFlags = 4'b0000; CondEval = 1'b0; FlagW = 2'b00;
    PCS = 1'b0; NextPC = 1'b0; RegW = 1'b0; MemW = 1'b0;
  endtask

  // Evaluate condition c for one edge
  task automatic eval(input logic [3:0] c);
    Cond = c; CondEval = 1'b1;
    tick();
    CondEval = 1'b0;
  endtask

  // Load the flags register with f (needs an always-true evaluation first)
  task automatic load_flags(input logic [3:0] f);
    eval(4'b1110);
    FlagW = 2'b11; ALUFlags = f;
    tick();
    FlagW = 2'b00; ALUFlags = 4'b0000;
  endtask

  typedef struct {
    logic [3:0] f;
    logic [3:0] c;
    logic       exp;
  } vec_t;

  vec_t vecs[10] = '{
    '{4'b0010, 4'b1000, 1'b1},  // HI, C=1 Z=0
    '{4'b0110, 4'b1000, 1'b0},  // HI, Z=1
    '{4'b1000, 4'b1010, 1'b0},  // GE, N=1 V=0
    '{4'b1001, 4'b1100, 1'b1},  // GT, N=V, Z=0
    '{4'b0101, 4'b1101, 1'b1},  // LE, Z=1
    '{4'b0000, 4'b1011, 1'b0},  // LT, N=V
    '{4'b0000, 4'b1111, 1'b1},  // 1111 always
    '{4'b0001, 4'b0110, 1'b1},  // VS
    '{4'b0000, 4'b0011, 1'b1},  // CC
    '{4'b1000, 4'b0101, 1'b0}   // PL, N=1
  };

  initial begin
    idle_inputs();
    reset = 1'b0;
    #2;
    RegW = 1'b1; MemW = 1'b1; PCS = 1'b1;
    #1;
    chk("rst_flags", 32'(Flags), 32'h0);
    chk("rst_condex", 32'(CondEx), 32'h0);
    chk("rst_regwrite", 32'(RegWrite), 32'h0);
    chk("rst_memwrite", 32'(MemWrite), 32'h0);
    chk("rst_pcwrite_pcs", 32'(PCWrite), 32'h0);
    NextPC = 1'b1;
    #1;
    chk("rst_pcwrite_next", 32'(PCWrite), 32'h1);
    tick();
    reset = 1'b1;
    idle_inputs();
    tick();

    NextPC = 1'b1;
    #1;
    chk("fetch_pcwrite", 32'(PCWrite), 32'h1);
    chk("fetch_regwrite", 32'(RegWrite), 32'h0);
    chk("fetch_memwrite", 32'(MemWrite), 32'h0);
    chk("fetch_flags", 32'(Flags), 32'h0);
    NextPC = 1'b0;

    load_flags(4'b0100);
    chk("load_z", 32'(Flags), 32'h4);

    eval(4'b0000);
    RegW = 1'b1; MemW = 1'b1;
    #1;
    chk("eq_condex", 32'(CondEx), 32'h1);
    chk("eq_regwrite", 32'(RegWrite), 32'h1);
    chk("eq_memwrite", 32'(MemWrite), 32'h1);
    RegW = 1'b0; MemW = 1'b0;
    eval(4'b0001);
    RegW = 1'b1; MemW = 1'b1;
    #1;
    chk("ne_condex", 32'(CondEx), 32'h0);
    chk("ne_regwrite", 32'(RegWrite), 32'h0);
    chk("ne_memwrite", 32'(MemWrite), 32'h0);
    RegW = 1'b0; MemW = 1'b0;

    eval(4'b1110);
    FlagW = 2'b10; ALUFlags = 4'b1011;
    tick();
    chk("flagw_nz", 32'(Flags), 32'h8);
    FlagW = 2'b01; ALUFlags = 4'b0111;
    tick();
    chk("flagw_cv", 32'(Flags), 32'hB);
    FlagW = 2'b00;

    eval(4'b0000);
    chk("squash_condex", 32'(CondEx), 32'h0);
    FlagW = 2'b11; ALUFlags = 4'b1111; PCS = 1'b1;
    #1;
    chk("squash_pcwrite", 32'(PCWrite), 32'h0);
    tick();
    chk("squash_flags", 32'(Flags), 32'hB);
    FlagW = 2'b00; PCS = 1'b0;

    eval(4'b1110);
    Cond = 4'b0000; CondEval = 1'b1; FlagW = 2'b11; ALUFlags = 4'b0100;
    tick();
    chk("same_cyc_flags", 32'(Flags), 32'h4);
    chk("same_cyc_condex", 32'(CondEx), 32'h0);
    CondEval = 1'b0; FlagW = 2'b00;

    // Held CondEval: last evaluated value wins (Z=1 now)
    Cond = 4'b0001; CondEval = 1'b1;
    tick();
    chk("hold_first", 32'(CondEx), 32'h0);
    Cond = 4'b0000;
    tick();
    chk("hold_last", 32'(CondEx), 32'h1);
    CondEval = 1'b0;

    foreach (vecs[i]) begin
      load_flags(vecs[i].f);
      ALUFlags = ~vecs[i].f;
      eval(vecs[i].c);
      chk($sformatf("cond_tbl%0d", i), 32'(CondEx), 32'(vecs[i].exp));
    end

    eval(4'b1110);
    RegW = 1'b1; MemW = 1'b1;
    #1;
    chk("pre_rst_regwrite", 32'(RegWrite), 32'h1);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_regwrite", 32'(RegWrite), 32'h0);
    chk("mid_rst_memwrite", 32'(MemWrite), 32'h0);
    chk("mid_rst_flags", 32'(Flags), 32'h0);
    idle_inputs();
    tick();
    reset = 1'b1;
    tick();

`ifdef CONDUNIT_PERF_EN
    chk("perf_rst_exec", ExecCnt, 32'd0);
    chk("perf_rst_squash", SquashCnt, 32'd0);
    // Flags are 0000: NE/AL pass, EQ fails
    eval(4'b0001);
    eval(4'b0001);
    eval(4'b0000);
    eval(4'b1110);
    eval(4'b0000);
    chk("perf_exec", ExecCnt, 32'd3);
    chk("perf_squash", SquashCnt, 32'd2);
    tick();
    chk("perf_hold_exec", ExecCnt, 32'd3);
    eval(4'b0001);
    #2;
    reset = 1'b0;
    #1;
    chk("perf_mid_rst_exec", ExecCnt, 32'd0);
    chk("perf_mid_rst_squash", SquashCnt, 32'd0);
    tick();
    reset = 1'b1;
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
